// File: rtl/fpdiv_scheduler.sv
// Round-robin front end that time-shares one combinational fpdiv between NUM_REQ issue ports.
// One division in flight; operands are held on div_a/div_b for the whole multicycle window.
module fpdiv_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 2,
  parameter int TAG_W       = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*32-1:0]    req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [31:0]              div_a,
  output logic [31:0]              div_b,
  input  logic [31:0]              div_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy
);

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  grant;
  logic             grant_vld;
  logic [ID_W:0]    pick;

  // Returns {found, index}; the smallest distance after 'last' wins, so the loop
  // runs from the farthest candidate down and lets nearer hits overwrite.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] sel;
    int              idx;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (v[sel]) r = {1'b1, sel};
    end
    return r;
  endfunction

  always_comb begin
    pick      = rr_pick(req_valid, last_grant);
    grant_vld = pick[ID_W];
    grant     = pick[ID_W-1:0];
  end

  // Ready is the only combinational output; it is forced low while rst is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_vld)
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            div_a      <= req_a[32*grant +: 32];
            div_b      <= req_b[32*grant +: 32];
            rsp_id     <= grant;
            rsp_tag    <= req_tag[TAG_W*grant +: TAG_W];
            last_grant <= grant;
            cnt        <= CNT_W'(DIV_LATENCY - 1);
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // div_a/div_b have been stable for DIV_LATENCY cycles when cnt reaches zero.
          if (cnt == '0) begin
            rsp_result <= div_result;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_scheduler.sv
// Directed bench for fpdiv_scheduler with a table-driven stand-in for the shared fpdiv.
module tb_fpdiv_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [15:0]  req_tag;
  logic [31:0]  div_a;
  logic [31:0]  div_b;
  logic [31:0]  div_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_result;
  logic [1:0]   rsp_id;
  logic [3:0]   rsp_tag;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  fpdiv_scheduler #(.NUM_REQ(4), .DIV_LATENCY(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in divider: known quotients for the directed operands, a^b otherwise.
  always_comb begin
    case ({div_a, div_b})
      64'h40400000_40000000: div_result = 32'h3FC00000;
      64'h3F800000_00000000: div_result = 32'h7F800000;
      64'h00000000_00000000: div_result = 32'h7FFFFFF0;
      default:               div_result = div_a ^ div_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
    req_a[32*p +: 32]  = a;
    req_b[32*p +: 32]  = b;
    req_tag[4*p +: 4]  = tag;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp);
    int n;
    set_port(p, a, b, tag);
    req_valid = 4'(1 << p);
    #1;
    n = 0;
    while (!req_ready[p] && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    chk("issue_ready", 32'(req_ready), 32'(1 << p));
    @(negedge clk); #1;
    req_valid = '0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_div_a", div_a, a);
    chk("exec_div_b", div_b, b);
    n = 1;
    while (!rsp_valid && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rsp_latency", 32'(n), 32'd3);
    chk("rsp_result", rsp_result, exp);
    chk("rsp_id", 32'(rsp_id), 32'(p));
    chk("rsp_tag", 32'(rsp_tag), 32'(tag));
    @(negedge clk); #1;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    logic seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    req_valid = '0;
    @(negedge clk); rst = 1'b0; #1;

    // basic op, then IEEE special cases passed straight through
    issue(0, 32'h40400000, 32'h40000000, 4'd5, 32'h3FC00000);
    issue(0, 32'h3F800000, 32'h00000000, 4'd3, 32'h7F800000);
    issue(0, 32'h00000000, 32'h00000000, 4'd9, 32'h7FFFFFF0);

    // all four ports valid from reset: rotation 0,1,2,3,0 every 4 cycles
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) set_port(i, 32'h41000000 + i, 32'h3F800000, 4'(8 + i));
    req_valid = 4'hF;
    @(negedge clk); rst = 1'b0; #1;
    for (int c = 0; c < 20; c++) begin
      g = (c / 4) % 4;
      chk("rr_req_ready", 32'(req_ready), (c % 4 == 0) ? 32'(1 << g) : 32'd0);
      if (c % 4 == 3) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(rsp_id), 32'(g));
        chk("rr_rsp_result", rsp_result, (32'h41000000 + g) ^ 32'h3F800000);
        chk("rr_rsp_tag", 32'(rsp_tag), 32'(8 + g));
      end
      @(negedge clk); #1;
    end

    // backpressure: response held, no new grants while stalled
    rsp_ready = 1'b0;
    wait_rsp(n);
    chk("hold_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_id", 32'(rsp_id), 32'd1);
      chk("hold_result", rsp_result, 32'h41000001 ^ 32'h3F800000);
      chk("hold_tag", 32'(rsp_tag), 32'd9);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_grant", 32'(req_ready), 32'b0100);
    req_valid = '0;
    @(negedge clk); #1;

    // reset in the middle of EXEC aborts the op and rewinds the pointer
    set_port(0, 32'h40400000, 32'h40000000, 4'd4);
    req_valid = 4'b0001;
    #1;
    n = 0;
    while (!req_ready[0] && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_issue_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = 4'b0101;
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk); rst = 1'b0; #1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | rsp_valid;
      @(negedge clk); #1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    req_valid = 4'b0101;
    #1;
    chk("abort_first_grant", 32'(req_ready), 32'b0001);
    @(negedge clk); #1;
    req_valid = 4'b0100;
    wait_rsp(n);
    chk("abort_rsp_id0", 32'(rsp_id), 32'd0);
    chk("abort_rsp_res0", rsp_result, 32'h3FC00000);
    @(negedge clk); #1;
    chk("abort_second_grant", 32'(req_ready), 32'b0100);
    @(negedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    chk("abort_rsp_id2", 32'(rsp_id), 32'd2);
    @(negedge clk); #1;

    // last_grant=1 with ports 1 and 3 valid: 3 wins, then 1
    issue(1, 32'h40000000, 32'h3F800000, 4'd6, 32'h40000000 ^ 32'h3F800000);
    req_valid = 4'b1010;
    #1;
    chk("ptr_grant3", 32'(req_ready), 32'b1000);
    @(negedge clk); #1;
    req_valid = 4'b0010;
    wait_rsp(n);
    chk("ptr_rsp_id3", 32'(rsp_id), 32'd3);
    @(negedge clk); #1;
    chk("ptr_grant1", 32'(req_ready), 32'b0010);
    @(negedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    chk("ptr_rsp_id1", 32'(rsp_id), 32'd1);
    chk("ptr_rsp_tag1", 32'(rsp_tag), 32'd6);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
